countdown_timer_controller: RTL

COUNTDOWN_TIMER_CONTROLLER -- requirements
Module: countdown_timer_controller

---
 rtl/countdown_pkg.sv | 13 +
 rtl/down_counter_core.sv | 23 ++
 rtl/countdown_timer_controller.sv | 100 ++++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// Shared encodings and defaults for the countdown timer controller.
package countdown_pkg;

  localparam int WIDTH_DEFAULT = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/down_counter_core.sv
// Loadable down counter that saturates at zero; load takes priority over dec.
module down_counter_core #(
  parameter int WIDTH = countdown_pkg::WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer_controller.sv
// Countdown timer: FSM and reload register steering a down_counter_core.
// Handshake: start is level-sampled, accepted only in IDLE or DONE; abort wins over everything except reset.
module countdown_timer_controller
  import countdown_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             hold,
  input  logic             abort,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] reload_q;
  logic             reload_en;
  logic             cnt_load;
  logic             cnt_dec;
  logic [WIDTH-1:0] cnt_load_val;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      reload_q <= '0;
    end else begin
      state_q <= state_d;
      if (reload_en) begin
        reload_q <= load_val;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    reload_en    = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = '0;
    if (abort) begin
      // Loading zero clears the count without touching the reload register.
      state_d  = ST_IDLE;
      cnt_load = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            reload_en    = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = load_val;
            state_d      = (load_val == '0) ? ST_DONE : ST_RUN;
          end else if (state_q == ST_DONE) begin
            if (auto_reload && (reload_q != '0)) begin
              cnt_load     = 1'b1;
              cnt_load_val = reload_q;
              state_d      = ST_RUN;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_RUN: begin
          if (hold) begin
            state_d = ST_PAUSE;
          end else begin
            cnt_dec = (count != '0);
            // The decrement that lands on zero is the one that enters DONE.
            state_d = (count[WIDTH-1:1] == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (!hold) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  down_counter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_load_val),
    .count    (count)
  );

  assign state = state_q;
  assign busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign done  = (state_q == ST_DONE);

endmodule
